// File: rtl/bit_serial_comparator.sv
// ----------------------------------------------------------------------------
// bit_serial_comparator
//   Compares two unsigned WIDTH-bit operands one bit pair per clock, MSB
//   first, and reports A<B, A>B or A==B as registered one-hot results.
//
//   Timing: a start accepted at edge T examines bits WIDTH-1..0 at edges
//   T+1..T+WIDTH, enters DONE, and presents done (with updated results)
//   after edge T+WIDTH+1. The following IDLE cycle can accept a new start.
//
//   Optional build macro:
//     EARLY_EXIT_EN - leave SHIFT as soon as a bit pair differs; first
//                     mismatch at bit k gives done after edge T+WIDTH-k+1.
//
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  synchronous active-low reset
//   start  in  request a comparison (ignored unless IDLE)
//   a_in   in  operand A, WIDTH bits, unsigned
//   b_in   in  operand B, WIDTH bits, unsigned
//   busy   out high in SHIFT and DONE
//   done   out one-cycle pulse, results valid
//   less   out registered A < B
//   great  out registered A > B
//   equal  out registered A == B
// ----------------------------------------------------------------------------
module bit_serial_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             great,
  output logic             equal
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             lt;
  logic             gt;
  logic             eq;

  logic a_bit;
  logic b_bit;
  logic leave_shift;

  assign a_bit = a_sh[WIDTH-1];
  assign b_bit = b_sh[WIDTH-1];

`ifdef EARLY_EXIT_EN
  // Once eq drops the flags are frozen, so the remaining bits are irrelevant;
  // exit on the same edge the first differing pair is examined.
  assign leave_shift = (cnt == '0) || (eq && (a_bit ^ b_bit));
`else
  assign leave_shift = (cnt == '0);
`endif

  assign busy = (state != IDLE);

  // NOTE: every register here, including the operand shift registers, is
  // reset; they are few and small, and a clean post-reset state keeps the
  // lt/gt/eq flags and counter at known values for debug.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      lt    <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      done  <= 1'b0;
      less  <= 1'b0;
      great <= 1'b0;
      equal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; each register samples the
      // pre-edge values of all others, which is what the FSM relies on.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            eq    <= 1'b1;
            lt    <= 1'b0;
            gt    <= 1'b0;
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // First differing pair decides the order; later bits cannot change it.
          if (eq) begin
            lt <= ~a_bit & b_bit;
            gt <= a_bit & ~b_bit;
            eq <= ~(a_bit ^ b_bit);
          end
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          if (leave_shift) begin
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          less  <= lt;
          great <= gt;
          equal <= eq;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_comparator.sv
// ----------------------------------------------------------------------------
// tb_bit_serial_comparator
//   Scoreboard bench for bit_serial_comparator (WIDTH=8). Each accepted start
//   pushes the expected flags and the edge at which done must appear; a
//   monitor sampling 1 ns after every rising edge pops and compares them.
// ----------------------------------------------------------------------------
module tb_bit_serial_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         less;
  logic         great;
  logic         equal;

  bit_serial_comparator #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .less  (less),
    .great (great),
    .equal (equal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic l;
    logic g;
    logic e;
    int   due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_done = 0;
  bit   seen_done = 1'b0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Done latency from accepting edge, derived from the highest differing bit.
  function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = -1;
    for (int i = 0; i < W; i++) if (a[i] ^ b[i]) k = i;
`ifdef EARLY_EXIT_EN
    if (k >= 0) return W - k + 1;
`endif
    return W + 1;
  endfunction

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t x;
    x.l = (a < b);
    x.g = (a > b);
    x.e = (a == b);
    x.due = due;
    q.push_back(x);
  endtask

  // Monitor: compare every done pulse against the scoreboard head.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) seen_done = 1'b0;
      if (done === 1'b1) begin
        if (prev_done) check("done_one_cycle", 1, 0);
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t x;
          x = q.pop_front();
          check("done_cycle", cyc, x.due);
          check("less",  less,  x.l);
          check("great", great, x.g);
          check("equal", equal, x.e);
        end
        seen_done = 1'b1;
        n_done++;
      end
      if (seen_done && rst_n === 1'b1) check("onehot", $onehot({less, great, equal}), 1);
      prev_done = done;
    end
  end

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("timeout", n_done, target);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int target;
    target = n_done + 1;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    push(a, b, cyc + 1 + lat(a, b));
    @(negedge clk);
    start = 1'b0;
    a_in  = ~a;  // must not disturb the captured operands
    wait_done(target);
  endtask

  initial begin
    int e1;
    int e2;
    int target;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset with start held high: nothing may leave IDLE.
    rst_n = 1'b0;
    start = 1'b1;
    a_in  = 8'h12;
    b_in  = 8'h34;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_busy",  busy,  0);
      check("rst_done",  done,  0);
      check("rst_flags", {less, great, equal}, 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Directed cases, including the MSB-only and LSB-only mismatches.
    run_op(8'hA5, 8'hA5);
    run_op(8'h80, 8'h7F);
    run_op(8'h12, 8'h13);
    run_op(8'h00, 8'h00);
    run_op(8'hFF, 8'hFF);
    run_op(8'h00, 8'hFF);
    run_op(8'hFF, 8'hFE);
    run_op(8'h3C, 8'h5A);

    // start held high, a_in changed mid-SHIFT; second start taken in the
    // IDLE cycle right after DONE.
    target = n_done + 2;
    @(negedge clk);
    a_in  = 8'h5A;
    b_in  = 8'h3C;
    start = 1'b1;
    e1 = cyc + 1;
    push(8'h5A, 8'h3C, e1 + lat(8'h5A, 8'h3C));
    e2 = e1 + lat(8'h5A, 8'h3C) + 1;
    push(8'hFF, 8'h3C, e2 + lat(8'hFF, 8'h3C));
    @(negedge clk);
    a_in = 8'hFF;
    while (cyc < e2) @(negedge clk);
    start = 1'b0;
    wait_done(target);

    // Random operands.
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 3 == 0) ? ra : W'($urandom_range(0, 255));
      run_op(ra, rb);
    end

    // Reset during the 4th SHIFT cycle: abort, no done, outputs cleared.
    @(negedge clk);
    a_in  = 8'h01;
    b_in  = 8'h02;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy",  busy, 0);
    check("abort_done",  done, 0);
    check("abort_flags", {less, great, equal}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_flags_hold", {less, great, equal}, 0);

    run_op(8'h7F, 8'h80);

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_comparator.md
BIT_SERIAL_COMPARATOR -- requirements
Module: bit_serial_comparator

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port start  input  1  request to begin a comparison.
REQ-005 SHALL provide port a_in  input  WIDTH  operand A, unsigned.
REQ-006 SHALL provide port b_in  input  WIDTH  operand B, unsigned.
REQ-007 SHALL provide port busy  output  1  high while a comparison is in progress.
REQ-008 SHALL provide port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL provide port less  output  1  registered result, A < B.
REQ-010 SHALL provide port great  output  1  registered result, A > B.
REQ-011 SHALL provide port equal  output  1  registered result, A == B.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, SHALL capture a_in/b_in into shift registers, set working flags eq=1, lt=0, gt=0, load bit counter with WIDTH-1, and go to SHIFT.
REQ-014 SHALL ignore start in SHIFT and DONE; a_in/b_in changes after capture SHALL NOT affect the result.
REQ-015 Each SHIFT cycle SHALL examine one operand bit pair, MSB first: if eq=1 then lt=~a&b, gt=a&~b, eq=~(a^b); otherwise flags hold.
REQ-016 SHALL leave SHIFT for DONE in the cycle the counter reaches 0, after bit 0 is examined; otherwise the counter decrements.
REQ-017 In DONE, SHALL assert done=1 for exactly one cycle, copy working flags into less/great/equal, and return to IDLE next cycle.
REQ-018 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-019 Exactly one of less/great/equal SHALL be 1 from the first done pulse onward; the outputs SHALL hold until the next DONE.
REQ-020 Without early exit, start accepted at edge T SHALL give done=1 in cycle T+WIDTH+1.
REQ-021 A new start SHALL be accepted in the IDLE cycle directly following DONE (back-to-back throughput of one result per WIDTH+2 cycles).

Reset
REQ-022 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, less=0, great=0, equal=0, counter=0 and clear working flags, overriding start.
REQ-023 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse and no result update.

Configuration
REQ-024 Macro EARLY_EXIT_EN, when defined, SHALL make SHIFT go to DONE in the cycle after the first mismatching bit pair clears eq (first mismatch at bit k gives done at T+WIDTH-k+1).
REQ-025 Without EARLY_EXIT_EN, SHALL always spend exactly WIDTH cycles in SHIFT; equal-operand latency SHALL be identical in both builds.

Verification (WIDTH=8)
REQ-026 rst_n=0 for 2 cycles with start=1 -> busy=0, done=0, less=great=equal=0; no transition out of IDLE.
REQ-027 a_in=0xA5, b_in=0xA5, start at T -> done at T+9, equal=1, less=0, great=0, both builds.
REQ-028 a_in=0x80, b_in=0x7F -> great=1; done at T+9 without EARLY_EXIT_EN, at T+2 with it.
REQ-029 a_in=0x12, b_in=0x13 -> less=1, done at T+9 in both builds (mismatch only at bit 0).
REQ-030 start held high, a_in changed to 0xFF during SHIFT -> result reflects captured operands; second start accepted in IDLE cycle after DONE, done again 9 cycles later.
REQ-031 rst_n=0 during 4th SHIFT cycle -> IDLE next cycle, all outputs 0, no done pulse.
